pipe_buffer: RTL and testbench
==============================

# pipe_buffer

Parametrised inter-stage buffer for the core pipeline, replacing single-register valid/ack coupling between stages (IF→ID, ID→EX, EX→MEM, MEM→WB) with a DEPTH-entry FIFO. It stores WIDTH-bit stage payloads (instr, pc, operands packed by the instantiating stage) and honours the pipeline's flush and debug-halt controls. A FALLTHROUGH mode gives zero-latency forwarding when empty.

## Interface
- WIDTH, 32: payload width in bits, ≥1
- DEPTH, 2: number of entries, ≥2, need not be a power of two
- FALLTHROUGH, 0: 1 = payload passes combinationally to output when buffer empty; 0 = minimum one-cycle latency
- clk  in  1  clock; all state updates on rising edge
- rst_i  in  1  synchronous reset, active-high
- flush_i  in  1  discard all stored entries (taken branch / debug flush)
- halt_i  in  1  freeze both sides; contents preserved (debug halt)
- valid_i  in  1  upstream payload valid
- data_i  in  WIDTH  upstream payload
- ack_o  out  1  buffer accepts upstream payload this cycle
- valid_o  out  1  payload available downstream
- data_o  out  WIDTH  head payload; 0 when valid_o=0
- ack_i  in  1  downstream consumes head this cycle
- count_o  out  $clog2(DEPTH+1)  number of stored entries

## Operation
- Storage: DEPTH×WIDTH array, read pointer rptr, write pointer wptr, counter cnt; pointers wrap from DEPTH-1 to 0.
- Push = valid_i & ack_o; pop = valid_o & ack_i. Both evaluated in the same cycle.
- ack_o = !rst_i & !flush_i & !halt_i & (cnt < DEPTH). No combinational path from ack_i to ack_o: when full, simultaneous pop does not allow a push that cycle.
- valid_o = !rst_i & !flush_i & !halt_i & (cnt > 0 | (FALLTHROUGH & valid_i)).
- data_o = mem[rptr] when cnt>0; data_i when cnt=0 and FALLTHROUGH and valid_i; otherwise 0.
- Fallthrough bypass (cnt=0, push and pop same cycle): payload consumed directly, not written; cnt, pointers unchanged.
- Otherwise push writes mem[wptr], wptr++; pop advances rptr; cnt += push − pop.
- Priority: rst_i > flush_i > halt_i > normal operation.
- flush_i: next edge rptr=wptr=cnt=0; no push or pop in the flush cycle. Array contents need not be cleared.
- halt_i: pointers, cnt, array held; ack_o=0, valid_o=0. On deassertion, previously stored entries re-present in original order.
- Upstream must hold valid_i/data_i stable until ack_o; buffer does not rely on this for correctness.

## Timing
- Reset values (during and on edge after rst_i): cnt=0, rptr=wptr=0, count_o=0, valid_o=0, ack_o=0, data_o=0.
- FALLTHROUGH=0: push at cycle N → valid_o at N+1 earliest.
- FALLTHROUGH=1: push at cycle N into empty buffer → valid_o and data_o at N (combinational).
- Sustained throughput: 1 payload/cycle when downstream acks every cycle and cnt<DEPTH.
- Full (cnt=DEPTH): ack_o=0; one pop frees slot, ack_o=1 next cycle.
- count_o is registered cnt; reflects push/pop of cycle N at N+1.
- Reset or flush asserted mid-stream: in-flight payloads lost; upstream valid_i in that cycle not accepted.
- Pointer wrap: push/pop at index DEPTH-1 moves pointer to 0 with no bubble.

## Test plan
- Reset: rst_i=1 for 2 cycles with valid_i=1 → valid_o=0, ack_o=0, count_o=0, data_o=0; first push after release lands at entry 0.
- Fill/drain, WIDTH=32, DEPTH=3, FALLTHROUGH=0, ack_i=0: push 0xA0,0xA1,0xA2 → count_o=3, ack_o=0; 4th payload 0xA3 held off; ack_i=1 → 0xA0,0xA1,0xA2,0xA3 in order, count_o returns to 0.
- Wrap-around, DEPTH=3, continuous push/pop for 10 payloads 0..9 with ack_i=1 → output 0..9 in order, one per cycle after first-cycle latency, no drops.
- Fallthrough, FALLTHROUGH=1, empty, valid_i=1 data_i=0x55, ack_i=1 → valid_o=1, data_o=0x55 same cycle, count_o stays 0.
- Flush, 2 entries stored, flush_i=1 for 1 cycle with valid_i=1 data_i=0x77 → valid_o=ack_o=0 that cycle, count_o=0 next cycle, 0x77 not stored.
- Halt, 2 entries (0x11,0x22), halt_i=1 for 5 cycles with ack_i=1, valid_i=1 → no push/pop, count_o=2; after release, 0x11 then 0x22 delivered.

Source files
------------

// File: rtl/pipe_buffer.sv
// Inter-stage pipeline buffer: DEPTH-entry FIFO with flush, debug halt and an
// optional zero-latency fallthrough path when empty.
module pipe_buffer #(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 2,
  parameter int FALLTHROUGH = 0
) (
  input  logic                       clk,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       halt_i,
  input  logic                       valid_i,
  input  logic [WIDTH-1:0]           data_i,
  output logic                       ack_o,
  output logic                       valid_o,
  output logic [WIDTH-1:0]           data_o,
  input  logic                       ack_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_IDX  = PW'(DEPTH - 1);
  localparam bit FT = (FALLTHROUGH != 0);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rptr;
  logic [PW-1:0]    wptr;
  logic [CW-1:0]    cnt;

  logic active;
  logic empty;
  logic push;
  logic pop;
  logic bypass;
  logic do_push;
  logic do_pop;

  // ack_o depends only on occupancy, never on ack_i, so a full buffer
  // cannot accept a payload in the same cycle it frees a slot.
  assign active  = !rst_i && !flush_i && !halt_i;
  assign empty   = (cnt == '0);
  assign ack_o   = active && (cnt < DEPTH_CNT);
  assign valid_o = active && (!empty || (FT && valid_i));
  assign push    = valid_i && ack_o;
  assign pop     = valid_o && ack_i;
  assign bypass  = FT && empty && push && pop;
  assign do_push = push && !bypass;
  assign do_pop  = pop && !bypass;
  assign count_o = cnt;

  always_comb begin
    data_o = '0;
    if (valid_o) begin
      if (!empty) data_o = mem[rptr];
      else        data_o = data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= data_i;
  end

  always_ff @(posedge clk) begin
    if (rst_i || flush_i) begin
      rptr <= '0;
      wptr <= '0;
      cnt  <= '0;
    end else if (!halt_i) begin
      if (do_push) wptr <= (wptr == LAST_IDX) ? '0 : wptr + 1'b1;
      if (do_pop)  rptr <= (rptr == LAST_IDX) ? '0 : rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_buffer.sv
// Drives a FALLTHROUGH=0 and a FALLTHROUGH=1 buffer (both DEPTH=3) with the
// same stimulus and compares each against a queue-based reference.
module tb_pipe_buffer;

  logic        clk = 1'b0;
  logic        rst_i, flush_i, halt_i, valid_i, ack_i;
  logic [31:0] data_i;

  logic        ack_w   [2];
  logic        valid_w [2];
  logic [31:0] data_w  [2];
  logic [1:0]  count_w [2];

  logic [31:0] q [2][$];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pipe_buffer #(.WIDTH(32), .DEPTH(3), .FALLTHROUGH(0)) u_dut0 (
    .clk(clk), .rst_i(rst_i), .flush_i(flush_i), .halt_i(halt_i),
    .valid_i(valid_i), .data_i(data_i), .ack_o(ack_w[0]), .valid_o(valid_w[0]),
    .data_o(data_w[0]), .ack_i(ack_i), .count_o(count_w[0])
  );

  pipe_buffer #(.WIDTH(32), .DEPTH(3), .FALLTHROUGH(1)) u_dut1 (
    .clk(clk), .rst_i(rst_i), .flush_i(flush_i), .halt_i(halt_i),
    .valid_i(valid_i), .data_i(data_i), .ack_o(ack_w[1]), .valid_o(valid_w[1]),
    .data_o(data_w[1]), .ack_i(ack_i), .count_o(count_w[1])
  );

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One cycle: inputs set mid-low phase, outputs checked against the queue
  // model, then the model advances with the decisions made before the edge.
  task automatic apply_stimulus(input logic rst, input logic flush, input logic halt,
                                input logic valid, input logic [31:0] data, input logic ack);
    bit          pushed [2];
    bit          popped [2];
    int          sz     [2];
    bit          act, e_ack, e_valid;
    logic [31:0] e_data;
    rst_i = rst; flush_i = flush; halt_i = halt;
    valid_i = valid; data_i = data; ack_i = ack;
    #1;
    act = !rst && !flush && !halt;
    for (int i = 0; i < 2; i++) begin
      sz[i]   = q[i].size();
      e_ack   = act && (sz[i] < 3);
      e_valid = act && (sz[i] > 0 || (i == 1 && valid));
      e_data  = !e_valid ? 32'h0 : (sz[i] > 0 ? q[i][0] : data);
      check_output($sformatf("ft%0d_ack_o", i), {31'h0, ack_w[i]}, {31'h0, e_ack});
      check_output($sformatf("ft%0d_valid_o", i), {31'h0, valid_w[i]}, {31'h0, e_valid});
      check_output($sformatf("ft%0d_data_o", i), data_w[i], e_data);
      check_output($sformatf("ft%0d_count_o", i), {30'h0, count_w[i]}, sz[i]);
      pushed[i] = valid && e_ack;
      popped[i] = e_valid && ack;
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (rst || flush) begin
        q[i].delete();
      end else begin
        if (popped[i] && sz[i] > 0) void'(q[i].pop_front());
        if (pushed[i] && !(popped[i] && sz[i] == 0)) q[i].push_back(data);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst_i = 1'b1; flush_i = 1'b0; halt_i = 1'b0;
    valid_i = 1'b1; data_i = 32'hDEAD; ack_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    apply_stimulus(1, 0, 0, 1, 32'hDEAD, 0);

    // Fill to full with downstream stalled, hold off a fourth, then drain.
    apply_stimulus(0, 0, 0, 1, 32'hA0, 0);
    apply_stimulus(0, 0, 0, 1, 32'hA1, 0);
    apply_stimulus(0, 0, 0, 1, 32'hA2, 0);
    check_output("full_count", {30'h0, count_w[0]}, 32'd3);
    check_output("full_ack", {31'h0, ack_w[0]}, 32'd0);
    apply_stimulus(0, 0, 0, 1, 32'hA3, 0);
    for (int i = 0; i < 6; i++) apply_stimulus(0, 0, 0, (i < 2), 32'hA3, 1);
    check_output("drained_count", {30'h0, count_w[0]}, 32'd0);

    // Continuous stream exercising pointer wrap.
    for (int i = 0; i < 10; i++) apply_stimulus(0, 0, 0, 1, i, 1);
    apply_stimulus(0, 0, 0, 0, 0, 1);
    apply_stimulus(0, 0, 0, 0, 0, 1);

    // Fallthrough from empty.
    valid_i = 1'b1; data_i = 32'h55; ack_i = 1'b1;
    #1;
    check_output("bypass_valid", {31'h0, valid_w[1]}, 32'd1);
    check_output("bypass_data", data_w[1], 32'h55);
    apply_stimulus(0, 0, 0, 1, 32'h55, 1);
    check_output("bypass_count", {30'h0, count_w[1]}, 32'd0);
    apply_stimulus(0, 0, 0, 0, 0, 1);

    // Flush with two stored entries and a payload offered in the flush cycle.
    apply_stimulus(0, 0, 0, 1, 32'h31, 0);
    apply_stimulus(0, 0, 0, 1, 32'h32, 0);
    apply_stimulus(0, 1, 0, 1, 32'h77, 1);
    check_output("flush_count", {30'h0, count_w[0]}, 32'd0);
    apply_stimulus(0, 0, 0, 0, 0, 1);

    // Halt preserves contents and order.
    apply_stimulus(0, 0, 0, 1, 32'h11, 0);
    apply_stimulus(0, 0, 0, 1, 32'h22, 0);
    for (int i = 0; i < 5; i++) apply_stimulus(0, 0, 1, 1, 32'h99, 1);
    check_output("halt_count", {30'h0, count_w[0]}, 32'd2);
    valid_i = 1'b0; halt_i = 1'b0;
    #1;
    check_output("halt_release_data", data_w[0], 32'h11);
    for (int i = 0; i < 3; i++) apply_stimulus(0, 0, 0, 0, 0, 1);

    // Randomised traffic with occasional reset, flush and halt.
    for (int i = 0; i < 600; i++) begin
      apply_stimulus(($urandom_range(0, 79) == 0), ($urandom_range(0, 29) == 0),
                     ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) < 7),
                     $urandom, ($urandom_range(0, 9) < 6));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
